// File: rtl/peripheral_divider.sv
// Memory-mapped unsigned restoring divider: write A/B, start via INIT,
// poll DONE, read packed {remainder, quotient}.
module peripheral_divider #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   d_in,
  input  logic               cs,
  input  logic [4:0]         addr,
  input  logic               rd,
  input  logic               wr,
  output logic [2*WIDTH-1:0] d_out
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [WIDTH-1:0]   rem, quo, div;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] result;
  logic               done;

  logic wr_en, rd_en, start, last_iter;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic [WIDTH-1:0]   rem_next, quo_next;
  logic [2*WIDTH-1:0] rd_data;

  assign wr_en     = cs & wr;
  assign rd_en     = cs & rd;
  assign start     = wr_en && (addr == 5'h0C) && d_in[0];
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // One restoring step; a zero divisor always "fits", giving all-ones quotient
  // and the dividend as remainder.
  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, div};
    rem_next  = rem_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], 1'b0};
    if (rem_shift >= {1'b0, div}) begin
      rem_next = rem_diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = BUSY;
    end else begin
      case (state)
        BUSY:    if (last_iter) state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      rem    <= '0;
      quo    <= '0;
      div    <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      if (wr_en && addr == 5'h04) a_reg <= d_in;
      if (wr_en && addr == 5'h08) b_reg <= d_in;
      if (start) begin
        rem  <= '0;
        quo  <= a_reg;
        div  <= b_reg;
        cnt  <= '0;
        done <= 1'b0;
      end else if (state == BUSY) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt + 1'b1;
        if (last_iter) begin
          result <= {rem_next, quo_next};
          done   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      5'h10:   rd_data = result;
      5'h14:   rd_data = {{(2*WIDTH-1){1'b0}}, done};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)      d_out <= '0;
    else if (rd_en) d_out <= rd_data;
    else            d_out <= '0;
  end

endmodule

// File: tb/tb_peripheral_divider.sv
// Directed and randomized bus-level checks of peripheral_divider against
// an arithmetic reference (/ and %) with exact done-latency checking.
module tb_peripheral_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] d_in = '0;
  logic        cs = 1'b0;
  logic [4:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] d_out;

  int checks = 0;
  int failures = 0;

  peripheral_divider #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] q, r;
    if (b == 16'd0) begin
      q = 16'hFFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk);
    #1;
    d = d_out;
    cs = 1'b0; rd = 1'b0; addr = '0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Poll DONE right after the start edge; done must first read 1 on the 17th read.
  task automatic wait_done(input string tag);
    logic [31:0] v;
    int lat;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      bus_read(5'h14, v);
      if (v == 32'd1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd17);
  endtask

  task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] v;
    bus_write(5'h04, a);
    bus_write(5'h08, b);
    bus_write(5'h0C, 16'h0001);
    wait_done(tag);
    bus_read(5'h10, v);
    check({tag, "_result"}, v, model(a, b));
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] ra, rb;

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_dout", d_out, 32'h0);
    bus_read(5'h14, v);
    check("reset_done", v, 32'h0);
    bus_read(5'h10, v);
    check("reset_result", v, 32'h0);

    // Directed examples
    run_div("t1_a_lt_b", 16'h0005, 16'h000F);
    check("t1_model", model(16'h0005, 16'h000F), 32'h00050000);
    bus_write(5'h04, 16'h000F);
    bus_write(5'h08, 16'h0005);
    bus_write(5'h0C, 16'h0001);
    idle_cycles(4);
    bus_read(5'h14, v);
    check("t2_done_busy", v, 32'h0);
    idle_cycles(16);
    bus_read(5'h10, v);
    check("t2_result", v, 32'h00000003);
    run_div("t3_ffff_1", 16'hFFFF, 16'h0001);
    run_div("t3_1234_10", 16'h1234, 16'h0010);
    run_div("t4_div0", 16'h0042, 16'h0000);
    bus_read(5'h14, v);
    check("t4_done_held", v, 32'h1);

    // INIT with d_in[0]=0 must not start; done and result remain
    bus_write(5'h0C, 16'h0002);
    idle_cycles(3);
    bus_read(5'h14, v);
    check("init0_ignored_done", v, 32'h1);
    bus_read(5'h10, v);
    check("init0_ignored_result", v, 32'h0042FFFF);

    // Reset mid-division
    bus_write(5'h04, 16'h1234);
    bus_write(5'h08, 16'h0007);
    bus_write(5'h0C, 16'h0001);
    idle_cycles(7);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycles(20);
    bus_read(5'h14, v);
    check("t5_done_after_reset", v, 32'h0);
    bus_read(5'h10, v);
    check("t5_result_after_reset", v, 32'h0);
    bus_write(5'h0C, 16'h0001);
    wait_done("t5_zero_regs");
    bus_read(5'h10, v);
    check("t5_zero_regs_result", v, model(16'h0, 16'h0));
    run_div("t5_resume", 16'h1234, 16'h0007);

    // Decode and read-data rules
    @(negedge clk);
    cs = 1'b0; rd = 1'b1; addr = 5'h10;
    @(posedge clk);
    #1;
    check("t6_read_cs0", d_out, 32'h0);
    rd = 1'b0; addr = '0;
    bus_read(5'h00, v);
    check("t6_read_addr0", v, 32'h0);
    bus_read(5'h04, v);
    check("t6_read_addrA", v, 32'h0);
    bus_read(5'h10, v);
    check("t6_read_result", v, model(16'h1234, 16'h0007));
    idle_cycles(1);
    check("t6_dout_clears", d_out, 32'h0);
    bus_write(5'h10, 16'hBEEF);
    bus_write(5'h14, 16'h0000);
    bus_read(5'h10, v);
    check("t6_ro_result", v, model(16'h1234, 16'h0007));
    bus_read(5'h14, v);
    check("t6_ro_done", v, 32'h1);

    // Simultaneous rd&wr: write takes effect, d_out follows the read
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 5'h04; d_in = 16'h0064;
    @(posedge clk);
    #1;
    check("t6_rdwr_dout", d_out, 32'h0);
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    bus_write(5'h08, 16'h0007);
    bus_write(5'h0C, 16'h0001);
    idle_cycles(4);
    // A written while busy must not disturb the running division
    bus_write(5'h04, 16'h00C8);
    idle_cycles(14);
    bus_read(5'h10, v);
    check("t6_a_write_while_busy", v, model(16'h0064, 16'h0007));

    // Restart while busy uses the current A and restarts the latency
    bus_write(5'h0C, 16'h0001);
    idle_cycles(5);
    bus_write(5'h04, 16'h1111);
    bus_write(5'h0C, 16'h0001);
    wait_done("t6_restart");
    bus_read(5'h10, v);
    check("t6_restart_result", v, model(16'h1111, 16'h0007));

    // Randomized operands
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'h0;
        1:       rb = 16'($urandom_range(1, 15));
        2:       rb = ra + 16'($urandom_range(1, 100));
        default: rb = 16'($urandom);
      endcase
      run_div($sformatf("rand%0d", i), ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
